// File: rtl/hazard_pkg.sv
// Shared constants for the hazard skid register: state encoding and the default bubble word.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } skid_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/hazard_stat_ctr.sv
// Saturating statistics counter: counts inc cycles, sticks at all-ones, cleared only by clr_n.
module hazard_stat_ctr #(
  parameter int STATW = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [STATW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + STATW'(1);
    end
  end

endmodule

// File: rtl/hazard_skid_reg.sv
// Two-entry valid/ready skid register with flush-to-bubble between pipeline stages.
// Define HAZ_STAT_EN to add the stall/flush statistics counters and their ports.
module hazard_skid_reg
  import hazard_pkg::*;
#(
  parameter int                   DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] BUBBLE    = DATAWIDTH'(NOP_WORD),
  parameter int                   STATW     = 16
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_data
`ifdef HAZ_STAT_EN
  ,
  output logic [STATW-1:0]     stat_stall_cnt,
  output logic [STATW-1:0]     stat_flush_cnt
`endif
);

  if (DATAWIDTH < 1 || STATW < 1) begin : g_param_chk
    $error("hazard_skid_reg: DATAWIDTH and STATW must be positive");
  end

  skid_state_t          state;
  logic [DATAWIDTH-1:0] main_slot;
  logic [DATAWIDTH-1:0] skid_slot;
  logic                 in_fire;
  logic                 out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_slot;

  // in_ready and out_valid are their own flops so neither port sees a combinational path.
  always_ff @(posedge clk) begin
    if (!clr_n || flush) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_slot <= BUBBLE;
      skid_slot <= BUBBLE;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state     <= ST_ONE;
            out_valid <= 1'b1;
            main_slot <= in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_slot <= in_data;
          end else if (in_fire) begin
            state     <= ST_TWO;
            in_ready  <= 1'b0;
            skid_slot <= in_data;
          end else if (out_fire) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            main_slot <= BUBBLE;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state     <= ST_ONE;
            in_ready  <= 1'b1;
            main_slot <= skid_slot;
            skid_slot <= BUBBLE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          main_slot <= BUBBLE;
          skid_slot <= BUBBLE;
        end
      endcase
    end
  end

`ifdef HAZ_STAT_EN
  logic stall_inc;
  logic flush_inc;

  // A flush cycle is not a stall; a flush of an empty stage discards nothing.
  assign stall_inc = out_valid & ~out_ready & ~flush;
  assign flush_inc = flush & (state != ST_EMPTY);

  hazard_stat_ctr #(.STATW(STATW)) u_stall_ctr (
    .clk   (clk),
    .clr_n (clr_n),
    .inc   (stall_inc),
    .cnt   (stat_stall_cnt)
  );

  hazard_stat_ctr #(.STATW(STATW)) u_flush_ctr (
    .clk   (clk),
    .clr_n (clr_n),
    .inc   (flush_inc),
    .cnt   (stat_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_skid_reg.sv
// Bench for hazard_skid_reg: two instances (zero and all-ones bubble) share one stimulus and one FIFO model.
module tb_hazard_skid_reg;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [31:0] out_data0, out_data1;
`ifdef HAZ_STAT_EN
  logic [15:0] stall0, flushc0;
  logic [3:0]  stall1, flushc1;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hazard_skid_reg #(.DATAWIDTH(32), .BUBBLE(32'h0000_0000), .STATW(16)) dut0 (
    .clk (clk), .clr_n (clr_n), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready0), .in_data (in_data),
    .out_valid (out_valid0), .out_ready (out_ready), .out_data (out_data0)
`ifdef HAZ_STAT_EN
    , .stat_stall_cnt (stall0), .stat_flush_cnt (flushc0)
`endif
  );

  hazard_skid_reg #(.DATAWIDTH(32), .BUBBLE(32'hFFFF_FFFF), .STATW(4)) dut1 (
    .clk (clk), .clr_n (clr_n), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready1), .in_data (in_data),
    .out_valid (out_valid1), .out_ready (out_ready), .out_data (out_data1)
`ifdef HAZ_STAT_EN
    , .stat_stall_cnt (stall1), .stat_flush_cnt (flushc1)
`endif
  );

  // Model: a capacity-2 FIFO; ready means room at the start of the cycle.
  logic [31:0] q[$];
  logic [15:0] m_stall0, m_flush0;
  logic [3:0]  m_stall1, m_flush1;

  always @(posedge clk) begin
    if (!clr_n) begin
      q.delete();
      m_stall0 = '0; m_flush0 = '0;
      m_stall1 = '0; m_flush1 = '0;
    end else begin
      automatic bit acc = in_valid && (q.size() < 2);
      automatic bit dlv = (q.size() > 0) && out_ready;
      if (q.size() > 0 && !out_ready && !flush) begin
        if (m_stall0 != 16'hFFFF) m_stall0 = m_stall0 + 16'd1;
        if (m_stall1 != 4'hF)     m_stall1 = m_stall1 + 4'd1;
      end
      if (flush && q.size() > 0) begin
        if (m_flush0 != 16'hFFFF) m_flush0 = m_flush0 + 16'd1;
        if (m_flush1 != 4'hF)     m_flush1 = m_flush1 + 4'd1;
      end
      if (dlv) void'(q.pop_front());
      if (flush) q.delete();
      else if (acc) q.push_back(in_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit          mv  = q.size() > 0;
      automatic logic [31:0] md0 = mv ? q[0] : 32'h0000_0000;
      automatic logic [31:0] md1 = mv ? q[0] : 32'hFFFF_FFFF;
      chk("m_out_valid0", 32'(out_valid0), 32'(mv));
      chk("m_out_valid1", 32'(out_valid1), 32'(mv));
      chk("m_in_ready0", 32'(in_ready0), 32'(q.size() < 2));
      chk("m_in_ready1", 32'(in_ready1), 32'(q.size() < 2));
      chk("m_out_data0", out_data0, md0);
      chk("m_out_data1", out_data1, md1);
`ifdef HAZ_STAT_EN
      chk("m_stall0", 32'(stall0), 32'(m_stall0));
      chk("m_stall1", 32'(stall1), 32'(m_stall1));
      chk("m_flush0", 32'(flushc0), 32'(m_flush0));
      chk("m_flush1", 32'(flushc1), 32'(m_flush1));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit r, input bit f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  initial begin
    clr_n = 1'b0;
    drive(1'b1, 32'h0000_1234, 1'b0, 1'b0);
    repeat (2) step();
    chk_en = 1'b1;
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_out_data0", out_data0, 32'h0000_0000);
    chk("rst_out_data1", out_data1, 32'hFFFF_FFFF);
`ifdef HAZ_STAT_EN
    chk("rst_stall_cnt", 32'(stall0), 32'd0);
    chk("rst_flush_cnt", 32'(flushc0), 32'd0);
`endif

    // Streaming A, B, C with downstream always ready.
    clr_n = 1'b1;
    drive(1'b1, 32'hA000_000A, 1'b1, 1'b0); step();
    chk("strm_a", out_data0, 32'hA000_000A);
    chk("strm_a_vld", 32'(out_valid0), 32'd1);
    drive(1'b1, 32'hB000_000B, 1'b1, 1'b0); step();
    chk("strm_b", out_data0, 32'hB000_000B);
    chk("strm_b_rdy", 32'(in_ready0), 32'd1);
    drive(1'b1, 32'hC000_000C, 1'b1, 1'b0); step();
    chk("strm_c", out_data0, 32'hC000_000C);
    drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    chk("strm_drain_vld", 32'(out_valid0), 32'd0);
    chk("strm_drain_bub1", out_data1, 32'hFFFF_FFFF);

    // Skid: downstream stalls, third word must wait.
    drive(1'b1, 32'h0000_00A1, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0000_00B2, 1'b0, 1'b0); step();
    chk("skid_two_rdy", 32'(in_ready0), 32'd0);
    chk("skid_hold_a", out_data0, 32'h0000_00A1);
    drive(1'b1, 32'h0000_00C3, 1'b0, 1'b0); step();
    chk("skid_c_refused", out_data0, 32'h0000_00A1);
    drive(1'b1, 32'h0000_00C3, 1'b1, 1'b0); step();
    chk("skid_b_out", out_data0, 32'h0000_00B2);
    chk("skid_rdy_back", 32'(in_ready0), 32'd1);
    drive(1'b1, 32'h0000_00C3, 1'b1, 1'b0); step();
    chk("skid_c_out", out_data0, 32'h0000_00C3);
    drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    chk("skid_empty", 32'(out_valid0), 32'd0);

    // Flush while full with a word offered: everything discarded.
    drive(1'b1, 32'h0000_00D4, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0000_00E5, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0000_00F6, 1'b0, 1'b1); step();
    chk("fl_vld", 32'(out_valid0), 32'd0);
    chk("fl_bub0", out_data0, 32'h0000_0000);
    chk("fl_bub1", out_data1, 32'hFFFF_FFFF);
    chk("fl_rdy", 32'(in_ready0), 32'd1);
`ifdef HAZ_STAT_EN
    chk("fl_cnt", 32'(flushc0), 32'd1);
`endif
    drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    chk("fl_dropped", 32'(out_valid0), 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b1); step();
`ifdef HAZ_STAT_EN
    chk("fl_empty_nocnt", 32'(flushc0), 32'd1);
`endif

    // Mixed valid/ready pattern, with a flush on a live entry midway.
    for (int i = 0; i < 32; i++) begin
      drive((i % 3) != 2, 32'h5000_0000 + 32'(i), (i % 4) < 2, i == 20);
      step();
    end
    repeat (3) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    end

    // Long stall on a single entry saturates the 4-bit counter.
    drive(1'b1, 32'h0000_0077, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (20) step();
    chk("stall_hold", out_data0, 32'h0000_0077);
`ifdef HAZ_STAT_EN
    chk("stall_sat", 32'(stall1), 32'd15);
`endif
    drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    chk("stall_drain_vld", 32'(out_valid1), 32'd0);
    chk("stall_drain_bub", out_data1, 32'hFFFF_FFFF);
`ifdef HAZ_STAT_EN
    chk("stall_sat_keep", 32'(stall1), 32'd15);
`endif

    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
